dcache_tag_array_nway: RTL and testbench
========================================

# dcache_tag_array_nway

N-way set-associative tag array for the data cache, generalising the single-way tag store to a parametrised number of ways, sets and tag width. It performs tag lookup with hit detection, tag fill and per-way invalidate, and picks a replacement victim per set. A built-in flush sequencer clears every valid bit after reset or on request, so no simulation-only initialisation is needed. It sits between the dcache controller FSM and the data store, and is inferred as block RAM plus flop-based replacement state.

## Interface
- NUM_WAYS, 4: associativity; power of two, 1..8
- NUM_SETS, 256: sets; power of two, ≥2
- TAG_WIDTH, 20: stored tag bits per way
- SET_W, $clog2(NUM_SETS): derived set index width
- WAY_W, max(1,$clog2(NUM_WAYS)): derived way index width

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- flush_req_i  in  1  start full-array invalidate
- busy_o  out  1  flush in progress; requests not accepted
- req_i  in  1  request valid; accepted when req_i & !busy_o
- we_i  in  1  fill: write tag_i into way way_i of set set_i, valid=1
- inv_i  in  1  invalidate way way_i of set set_i
- set_i  in  SET_W  set index
- way_i  in  WAY_W  way index for fill/invalidate
- tag_i  in  TAG_WIDTH  lookup/fill tag
- rvalid_o  out  1  lookup result valid
- hit_o  out  1  lookup hit
- hit_way_o  out  NUM_WAYS  one-hot hit way
- victim_way_o  out  WAY_W  way to replace for the looked-up set

## Operation
- Storage per set: NUM_WAYS × {valid, tag[TAG_WIDTH]} in one RAM word; valid is the MSB of each way slice. Per-set round-robin pointer (WAY_W bits) is held in flops.
- Request decode (accepted only): inv_i=1 → invalidate; else we_i=1 → fill; else → lookup. inv_i has priority over we_i.
- Lookup: reads the set, registers tag_i. On the next cycle, hit_way_o[w] = valid[w] & (tag[w]==tag_q), and hit_o = |hit_way_o. Multiple hits cannot occur when the controller is used correctly; if they do, hit_way_o reports all matches.
- victim_way_o: the lowest-index way with valid=0; if every way is valid, the set's round-robin pointer.
- Fill: byte-free whole-way write of {1,tag_i} into way_i; other ways are untouched. The set's pointer becomes (way_i+1) mod NUM_WAYS.
- Invalidate: clears the valid bit of way_i only; the tag is kept. The pointer is unchanged.
- Flush FSM has two states:
  - IDLE → FLUSH on rst_i, or on flush_req_i in IDLE. The counter loads to 0.
  - FLUSH: each cycle writes set[cnt] with every valid=0 and clears pointer[cnt], then increments cnt. After the write of set NUM_SETS-1, the FSM returns to IDLE; the counter wraps with no extra cycle.
  - flush_req_i while in FLUSH is ignored; there is no restart.
  - busy_o = (state==FLUSH).
- Requests with busy_o=1 are dropped: no read, no write, and no rvalid_o.

## Timing
- Reset values, from the cycle after rst_i is sampled high: busy_o=1, rvalid_o=0, hit_o=0, hit_way_o=0, victim_way_o=0, all pointers=0.
- Reset asserted mid-flush or mid-lookup: the flush restarts at set 0 and any pending rvalid_o is cancelled.
- Post-reset flush occupies exactly NUM_SETS cycles. busy_o falls on cycle NUM_SETS after reset deassertion, and the first request is accepted in that cycle.
- Lookup latency is 1: a request accepted in cycle N gives rvalid_o=1 with its result in cycle N+1 only. Outputs hold their values when rvalid_o=0.
- Fill and invalidate are single-cycle. Their effect is visible to a lookup accepted in the next cycle.
- Back-to-back lookups are sustained at 1 per cycle.
- flush_req_i asserted in the same cycle as an accepted lookup: the lookup completes (rvalid_o at N+1) and the flush starts at N+1.
- Same-set fill followed by lookup in the next cycle returns the new tag; there is no read-during-write hazard, because only one operation is accepted per cycle.

## Test plan
- Reset, then lookup of set 5 with tag 0x12345 → busy_o high for 256 cycles; then rvalid_o=1, hit_o=0, victim_way_o=0.
- Fill set 3 ways 0..3 with tags 0xA,0xB,0xC,0xD, then look up 0xC → hit_o=1, hit_way_o=4'b0100, victim_way_o=0 (pointer wrapped from way 3).
- Set 3 full; invalidate way 2; look up 0xC → hit_o=0, victim_way_o=2. Refill way 2, look up again → victim_way_o=3.
- Fill several sets, pulse flush_req_i; requests issued during the 256-cycle busy window get no rvalid_o. After the flush, every lookup misses and victim_way_o=0.
- Assert rst_i at flush cycle 100 → busy_o stays high for a full 256 cycles from deassertion, and rvalid_o=0 throughout.
- Random fill/invalidate/lookup traffic against a reference model: hit_o, hit_way_o and victim_way_o match every cycle; NUM_WAYS=1 and NUM_WAYS=8 builds both pass.

Source files
------------

// File: rtl/dcache_tag_array_nway.sv
// N-way set-associative dcache tag store: one RAM word per set holding {valid,tag} per way,
// flop-based round-robin victim pointers, and a flush sequencer that clears all valid bits.
module dcache_tag_array_nway #(
    parameter int NUM_WAYS  = 4,
    parameter int NUM_SETS  = 256,
    parameter int TAG_WIDTH = 20,
    parameter int SET_W     = $clog2(NUM_SETS),
    parameter int WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_req_i,
    output logic                 busy_o,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic                 inv_i,
    input  logic [SET_W-1:0]     set_i,
    input  logic [WAY_W-1:0]     way_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic                 rvalid_o,
    output logic                 hit_o,
    output logic [NUM_WAYS-1:0]  hit_way_o,
    output logic [WAY_W-1:0]     victim_way_o
);

    localparam int SLICE  = TAG_WIDTH + 1;
    localparam int WORD_W = NUM_WAYS * SLICE;

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [SET_W-1:0]     r_cnt;
    logic [SET_W-1:0]     w_cnt_next;

    logic [WORD_W-1:0]    r_mem [NUM_SETS];
    logic [WAY_W-1:0]     r_ptr [NUM_SETS];

    logic [WORD_W-1:0]    r_rdata;
    logic [TAG_WIDTH-1:0] r_tag_q;
    logic [WAY_W-1:0]     r_ptr_q;
    logic                 r_rvalid;

    logic                 w_busy;
    logic                 w_accept;
    logic                 w_do_inv;
    logic                 w_do_fill;
    logic                 w_do_lookup;
    logic [NUM_WAYS-1:0]  w_way_sel;
    logic [WAY_W-1:0]     w_ptr_fill;

    logic                 w_wr_en;
    logic [SET_W-1:0]     w_wr_addr;
    logic [NUM_WAYS-1:0]  w_tag_we;
    logic [NUM_WAYS-1:0]  w_vld_we;
    logic                 w_vld_val;

    logic [NUM_WAYS-1:0]  w_valid;
    logic [NUM_WAYS-1:0]  w_hit_way;
    logic [WAY_W-1:0]     w_victim;

    assign w_busy      = (r_state == S_FLUSH);
    assign w_accept    = req_i & ~w_busy & ~rst_i;
    assign w_do_inv    = w_accept & inv_i;
    assign w_do_fill   = w_accept & ~inv_i & we_i;
    assign w_do_lookup = w_accept & ~inv_i & ~we_i;
    assign w_ptr_fill  = (NUM_WAYS == 1) ? '0 : way_i + WAY_W'(1);

    // Flush sequencer: one set per cycle, counter wraps back to 0 on the last set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_FLUSH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (flush_req_i) begin
                    w_state_next = S_FLUSH;
                    w_cnt_next   = '0;
                end
            end
            S_FLUSH: begin
                w_cnt_next = r_cnt + SET_W'(1);
                if (r_cnt == SET_W'(NUM_SETS - 1)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
            assign w_way_sel[gi] = (way_i == WAY_W'(gi));
            assign w_valid[gi]   = r_rdata[gi*SLICE + TAG_WIDTH];
            assign w_hit_way[gi] = w_valid[gi] & (r_rdata[gi*SLICE +: TAG_WIDTH] == r_tag_q);
        end
    endgenerate

    // Per-way slice enables: fill writes valid+tag, invalidate and flush touch only valid bits.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = set_i;
        w_tag_we  = '0;
        w_vld_we  = '0;
        w_vld_val = 1'b0;
        if (w_busy) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_cnt;
            w_vld_we  = '1;
        end else if (w_do_fill || w_do_inv) begin
            w_wr_en   = 1'b1;
            w_vld_we  = w_way_sel;
            w_tag_we  = w_do_fill ? w_way_sel : '0;
            w_vld_val = w_do_fill;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (w_tag_we[w]) begin
                    r_mem[w_wr_addr][w*SLICE +: TAG_WIDTH] <= tag_i;
                end
                if (w_vld_we[w]) begin
                    r_mem[w_wr_addr][w*SLICE + TAG_WIDTH] <= w_vld_val;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_tag_q  <= '0;
            r_ptr_q  <= '0;
        end else begin
            r_rvalid <= w_do_lookup;
            if (w_do_lookup) begin
                r_rdata <= r_mem[set_i];
                r_tag_q <= tag_i;
                r_ptr_q <= r_ptr[set_i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_ptr[s] <= '0;
            end
        end else if (w_busy) begin
            r_ptr[r_cnt] <= '0;
        end else if (w_do_fill) begin
            r_ptr[set_i] <= w_ptr_fill;
        end
    end

    // Lowest free way wins; a full set falls back to its round-robin pointer.
    always_comb begin
        w_victim = r_ptr_q;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!w_valid[w]) begin
                w_victim = WAY_W'(w);
            end
        end
    end

    assign busy_o       = w_busy;
    assign rvalid_o     = r_rvalid;
    assign hit_way_o    = w_hit_way;
    assign hit_o        = |w_hit_way;
    assign victim_way_o = w_victim;

endmodule

// File: tb/tb_dcache_tag_array_nway.sv
// Bench for dcache_tag_array_nway: directed scenarios plus random traffic checked
// against an array-based model of valid bits, tags and per-set replacement pointers.
module tb_dcache_tag_array_nway;

    parameter int NUM_WAYS  = 4;
    parameter int NUM_SETS  = 256;
    parameter int TAG_WIDTH = 20;
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    logic                 clk = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 flush_req_i = 1'b0;
    logic                 busy_o;
    logic                 req_i = 1'b0;
    logic                 we_i = 1'b0;
    logic                 inv_i = 1'b0;
    logic [SET_W-1:0]     set_i = '0;
    logic [WAY_W-1:0]     way_i = '0;
    logic [TAG_WIDTH-1:0] tag_i = '0;
    logic                 rvalid_o;
    logic                 hit_o;
    logic [NUM_WAYS-1:0]  hit_way_o;
    logic [WAY_W-1:0]     victim_way_o;

    int checks = 0;
    int failures = 0;

    bit                   m_valid [NUM_SETS][NUM_WAYS];
    logic [TAG_WIDTH-1:0] m_tag   [NUM_SETS][NUM_WAYS];
    int                   m_ptr   [NUM_SETS];

    logic [NUM_WAYS-1:0]  last_hw;
    logic [WAY_W-1:0]     last_v;

    dcache_tag_array_nway #(
        .NUM_WAYS (NUM_WAYS),
        .NUM_SETS (NUM_SETS),
        .TAG_WIDTH(TAG_WIDTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_req_i (flush_req_i),
        .busy_o      (busy_o),
        .req_i       (req_i),
        .we_i        (we_i),
        .inv_i       (inv_i),
        .set_i       (set_i),
        .way_i       (way_i),
        .tag_i       (tag_i),
        .rvalid_o    (rvalid_o),
        .hit_o       (hit_o),
        .hit_way_o   (hit_way_o),
        .victim_way_o(victim_way_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_i = 1'b0;
        we_i = 1'b0;
        inv_i = 1'b0;
        flush_req_i = 1'b0;
    endtask

    task automatic model_flush();
        for (int s = 0; s < NUM_SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < NUM_WAYS; w++) m_valid[s][w] = 1'b0;
        end
    endtask

    function automatic logic [NUM_WAYS-1:0] m_hitway(int s, logic [TAG_WIDTH-1:0] t);
        logic [NUM_WAYS-1:0] hv = '0;
        for (int w = 0; w < NUM_WAYS; w++) hv[w] = m_valid[s][w] && (m_tag[s][w] == t);
        return hv;
    endfunction

    function automatic logic [WAY_W-1:0] m_victim(int s);
        for (int w = 0; w < NUM_WAYS; w++) if (!m_valid[s][w]) return WAY_W'(w);
        return WAY_W'(m_ptr[s]);
    endfunction

    // kind: 0 lookup, 1 fill, 2 invalidate; the model follows only accepted requests
    task automatic issue(input int kind, input int s, input int w, input logic [TAG_WIDTH-1:0] t);
        bit acc;
        req_i = 1'b1;
        we_i = (kind == 1);
        inv_i = (kind == 2);
        set_i = SET_W'(s);
        way_i = WAY_W'(w);
        tag_i = t;
        acc = (busy_o === 1'b0);
        tick();
        req_i = 1'b0;
        we_i = 1'b0;
        inv_i = 1'b0;
        if (acc && kind == 1) begin
            m_valid[s][w] = 1'b1;
            m_tag[s][w] = t;
            m_ptr[s] = (w + 1) % NUM_WAYS;
        end else if (acc && kind == 2) begin
            m_valid[s][w] = 1'b0;
        end
    endtask

    task automatic drive_rand();
        int k;
        k = $urandom_range(0, 2);
        req_i = 1'b1;
        we_i = (k == 1);
        inv_i = (k == 2);
        set_i = SET_W'($urandom_range(0, NUM_SETS - 1));
        way_i = WAY_W'($urandom_range(0, NUM_WAYS - 1));
        tag_i = TAG_WIDTH'($urandom);
    endtask

    task automatic test_reset();
        int n;
        logic [TAG_WIDTH-1:0] t;
        logic [NUM_WAYS-1:0] ehw;
        logic [WAY_W-1:0] ev;
        idle_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        checks += 5;
        if (busy_o !== 1'b1) begin failures++; $display("FAIL reset_busy: got %b expected 1", busy_o); end
        if (rvalid_o !== 1'b0) begin failures++; $display("FAIL reset_rvalid: got %b expected 0", rvalid_o); end
        if (hit_o !== 1'b0) begin failures++; $display("FAIL reset_hit: got %b expected 0", hit_o); end
        if (hit_way_o !== '0) begin failures++; $display("FAIL reset_hit_way: got %b expected 0", hit_way_o); end
        if (victim_way_o !== '0) begin failures++; $display("FAIL reset_victim: got %0d expected 0", victim_way_o); end
        model_flush();
        last_hw = '0;
        last_v = '0;
        rst_i = 1'b0;
        t = TAG_WIDTH'(32'h12345);
        req_i = 1'b1;
        set_i = SET_W'(5 % NUM_SETS);
        tag_i = t;
        n = 0;
        while (busy_o === 1'b1 && n < NUM_SETS + 8) begin
            checks++;
            if (rvalid_o !== 1'b0) begin failures++; $display("FAIL reset_busy_rvalid: cycle %0d got %b expected 0", n, rvalid_o); end
            tick();
            n++;
        end
        checks += 2;
        if (n != NUM_SETS) begin failures++; $display("FAIL reset_flush_len: got %0d expected %0d", n, NUM_SETS); end
        if (rvalid_o !== 1'b0) begin failures++; $display("FAIL reset_drop: got %b expected 0", rvalid_o); end
        ehw = m_hitway(5 % NUM_SETS, t);
        ev = m_victim(5 % NUM_SETS);
        tick();
        req_i = 1'b0;
        checks += 4;
        if (rvalid_o !== 1'b1) begin failures++; $display("FAIL first_rvalid: got %b expected 1", rvalid_o); end
        if (hit_o !== 1'b0) begin failures++; $display("FAIL first_hit: got %b expected 0", hit_o); end
        if (hit_way_o !== ehw) begin failures++; $display("FAIL first_hit_way: got %b expected %b", hit_way_o, ehw); end
        if (victim_way_o !== ev) begin failures++; $display("FAIL first_victim: got %0d expected %0d", victim_way_o, ev); end
        last_hw = ehw;
        last_v = ev;
    endtask

    task automatic test_fill_hit();
        logic [TAG_WIDTH-1:0] t;
        logic [NUM_WAYS-1:0] ehw;
        logic [WAY_W-1:0] ev;
        for (int w = 0; w < NUM_WAYS; w++) issue(1, 3, w, TAG_WIDTH'(10 + w));
        checks++;
        if (rvalid_o !== 1'b0) begin failures++; $display("FAIL fill_rvalid: got %b expected 0", rvalid_o); end
        t = TAG_WIDTH'(10 + (2 % NUM_WAYS));
        ehw = m_hitway(3, t);
        ev = m_victim(3);
        issue(0, 3, 0, t);
        checks += 4;
        if (rvalid_o !== 1'b1) begin failures++; $display("FAIL fill_lookup_rvalid: got %b expected 1", rvalid_o); end
        if (hit_o !== 1'b1) begin failures++; $display("FAIL fill_lookup_hit: got %b expected 1", hit_o); end
        if (hit_way_o !== ehw) begin failures++; $display("FAIL fill_lookup_hit_way: got %b expected %b", hit_way_o, ehw); end
        if (victim_way_o !== ev) begin failures++; $display("FAIL fill_lookup_victim: got %0d expected %0d", victim_way_o, ev); end
        last_hw = ehw;
        last_v = ev;
    endtask

    task automatic test_invalidate();
        int wi;
        logic [TAG_WIDTH-1:0] t;
        logic [NUM_WAYS-1:0] ehw;
        logic [WAY_W-1:0] ev;
        wi = 2 % NUM_WAYS;
        t = TAG_WIDTH'(10 + wi);
        issue(2, 3, wi, '0);
        ehw = m_hitway(3, t);
        ev = m_victim(3);
        issue(0, 3, 0, t);
        checks += 4;
        if (rvalid_o !== 1'b1) begin failures++; $display("FAIL inv_rvalid: got %b expected 1", rvalid_o); end
        if (hit_o !== 1'b0) begin failures++; $display("FAIL inv_hit: got %b expected 0", hit_o); end
        if (hit_way_o !== ehw) begin failures++; $display("FAIL inv_hit_way: got %b expected %b", hit_way_o, ehw); end
        if (victim_way_o !== WAY_W'(wi)) begin failures++; $display("FAIL inv_victim: got %0d expected %0d", victim_way_o, wi); end
        issue(1, 3, wi, t);
        ehw = m_hitway(3, t);
        ev = m_victim(3);
        issue(0, 3, 0, t);
        checks += 3;
        if (hit_o !== 1'b1) begin failures++; $display("FAIL refill_hit: got %b expected 1", hit_o); end
        if (hit_way_o !== ehw) begin failures++; $display("FAIL refill_hit_way: got %b expected %b", hit_way_o, ehw); end
        if (victim_way_o !== WAY_W'((wi + 1) % NUM_WAYS)) begin
            failures++; $display("FAIL refill_victim: got %0d expected %0d", victim_way_o, (wi + 1) % NUM_WAYS);
        end
        last_hw = ehw;
        last_v = ev;
    endtask

    task automatic test_flush();
        int n;
        int s;
        logic [NUM_WAYS-1:0] ehw;
        logic [WAY_W-1:0] ev;
        for (int i = 0; i < 12; i++)
            issue(1, $urandom_range(0, NUM_SETS - 1), $urandom_range(0, NUM_WAYS - 1), TAG_WIDTH'($urandom));
        ehw = m_hitway(3, TAG_WIDTH'(10));
        ev = m_victim(3);
        req_i = 1'b1;
        set_i = SET_W'(3);
        tag_i = TAG_WIDTH'(10);
        flush_req_i = 1'b1;
        tick();
        idle_inputs();
        checks += 4;
        if (rvalid_o !== 1'b1) begin failures++; $display("FAIL flushlk_rvalid: got %b expected 1", rvalid_o); end
        if (hit_way_o !== ehw) begin failures++; $display("FAIL flushlk_hit_way: got %b expected %b", hit_way_o, ehw); end
        if (victim_way_o !== ev) begin failures++; $display("FAIL flushlk_victim: got %0d expected %0d", victim_way_o, ev); end
        if (busy_o !== 1'b1) begin failures++; $display("FAIL flushlk_busy: got %b expected 1", busy_o); end
        last_hw = ehw;
        last_v = ev;
        model_flush();
        drive_rand();
        tick();
        n = 1;
        while (busy_o === 1'b1 && n < NUM_SETS + 8) begin
            checks++;
            if (rvalid_o !== 1'b0) begin failures++; $display("FAIL flush_busy_rvalid: cycle %0d got %b expected 0", n, rvalid_o); end
            drive_rand();
            tick();
            n++;
        end
        idle_inputs();
        checks += 2;
        if (n != NUM_SETS) begin failures++; $display("FAIL flush_len: got %0d expected %0d", n, NUM_SETS); end
        if (rvalid_o !== 1'b0) begin failures++; $display("FAIL flush_drop: got %b expected 0", rvalid_o); end
        for (int i = 0; i < 8; i++) begin
            s = (i == 0) ? 3 : $urandom_range(0, NUM_SETS - 1);
            issue(0, s, 0, TAG_WIDTH'($urandom_range(0, 15)));
            checks += 3;
            if (hit_o !== 1'b0) begin failures++; $display("FAIL postflush_hit set %0d: got %b expected 0", s, hit_o); end
            if (hit_way_o !== '0) begin failures++; $display("FAIL postflush_hit_way set %0d: got %b expected 0", s, hit_way_o); end
            if (victim_way_o !== '0) begin failures++; $display("FAIL postflush_victim set %0d: got %0d expected 0", s, victim_way_o); end
        end
        last_hw = '0;
        last_v = '0;
    endtask

    task automatic test_reset_midflush();
        int n;
        flush_req_i = 1'b1;
        tick();
        flush_req_i = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        rst_i = 1'b1;
        req_i = 1'b1;
        set_i = '0;
        tag_i = '0;
        tick();
        rst_i = 1'b0;
        model_flush();
        n = 0;
        while (busy_o === 1'b1 && n < NUM_SETS + 8) begin
            checks++;
            if (rvalid_o !== 1'b0) begin failures++; $display("FAIL midflush_rvalid: cycle %0d got %b expected 0", n, rvalid_o); end
            tick();
            n++;
        end
        req_i = 1'b0;
        checks += 2;
        if (n != NUM_SETS) begin failures++; $display("FAIL midflush_len: got %0d expected %0d", n, NUM_SETS); end
        if (rvalid_o !== 1'b0) begin failures++; $display("FAIL midflush_drop: got %b expected 0", rvalid_o); end
        tick();
        last_hw = '0;
        last_v = '0;
    endtask

    task automatic test_reset_lookup();
        int n;
        issue(1, 7, 0, TAG_WIDTH'(5));
        req_i = 1'b1;
        set_i = SET_W'(7);
        tag_i = TAG_WIDTH'(5);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        req_i = 1'b0;
        checks += 4;
        if (rvalid_o !== 1'b0) begin failures++; $display("FAIL rstlk_rvalid: got %b expected 0", rvalid_o); end
        if (hit_o !== 1'b0) begin failures++; $display("FAIL rstlk_hit: got %b expected 0", hit_o); end
        if (busy_o !== 1'b1) begin failures++; $display("FAIL rstlk_busy: got %b expected 1", busy_o); end
        if (victim_way_o !== '0) begin failures++; $display("FAIL rstlk_victim: got %0d expected 0", victim_way_o); end
        model_flush();
        n = 0;
        while (busy_o === 1'b1 && n < NUM_SETS + 8) begin
            tick();
            n++;
        end
        checks++;
        if (n != NUM_SETS) begin failures++; $display("FAIL rstlk_len: got %0d expected %0d", n, NUM_SETS); end
        issue(0, 7, 0, TAG_WIDTH'(5));
        checks++;
        if (hit_o !== 1'b0) begin failures++; $display("FAIL rstlk_after_hit: got %b expected 0", hit_o); end
        last_hw = '0;
        last_v = '0;
    endtask

    task automatic test_back_to_back();
        int k, s, w;
        logic [TAG_WIDTH-1:0] t;
        logic [NUM_WAYS-1:0] ehw;
        logic [WAY_W-1:0] ev;
        for (int i = 0; i < 2000; i++) begin
            k = $urandom_range(0, 9);
            k = (i == 0 || k < 5) ? 0 : (k < 8 ? 1 : 2);
            s = $urandom_range(0, 3);
            w = $urandom_range(0, NUM_WAYS - 1);
            t = TAG_WIDTH'($urandom_range(0, 3));
            ehw = m_hitway(s, t);
            ev = m_victim(s);
            issue(k, s, w, t);
            if (k == 0) begin
                checks += 4;
                if (rvalid_o !== 1'b1) begin failures++; $display("FAIL rnd_rvalid op %0d: got %b expected 1", i, rvalid_o); end
                if (hit_o !== (|ehw)) begin failures++; $display("FAIL rnd_hit op %0d set %0d: got %b expected %b", i, s, hit_o, |ehw); end
                if (hit_way_o !== ehw) begin failures++; $display("FAIL rnd_hit_way op %0d set %0d: got %b expected %b", i, s, hit_way_o, ehw); end
                if (victim_way_o !== ev) begin failures++; $display("FAIL rnd_victim op %0d set %0d: got %0d expected %0d", i, s, victim_way_o, ev); end
                last_hw = ehw;
                last_v = ev;
            end else begin
                checks += 3;
                if (rvalid_o !== 1'b0) begin failures++; $display("FAIL rnd_wr_rvalid op %0d: got %b expected 0", i, rvalid_o); end
                if (hit_way_o !== last_hw) begin failures++; $display("FAIL rnd_hold_hit_way op %0d: got %b expected %b", i, hit_way_o, last_hw); end
                if (victim_way_o !== last_v) begin failures++; $display("FAIL rnd_hold_victim op %0d: got %0d expected %0d", i, victim_way_o, last_v); end
            end
        end
    endtask

    initial begin
        for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < NUM_WAYS; w++) m_tag[s][w] = '0;
        model_flush();
        last_hw = '0;
        last_v = '0;
        test_reset();
        test_fill_hit();
        test_invalidate();
        test_flush();
        test_reset_midflush();
        test_reset_lookup();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
